// File: rtl/relay_mode_sequencer.sv
// Relay mode sequencer: break-before-make control of two exclusive relays.
// Ports: CLOCK_50, RESET_N, AUX_INPUT, MODE_VALID/MODE_BIT, FAULT_CLR in;
//   RELAY_A, RELAY_B, BUSY, FAULT, STATE_DBG out (all registered).
// Optional macro RELAY_MIN_HOLD_EN: enforce MIN_HOLD cycles in a drive
//   state before accepting a changeover (opposite request held pending).
module relay_mode_sequencer #(
    parameter int DEAD_TIME   = 4096,
    parameter int LOS_TIMEOUT = 5000000,
    parameter int MIN_HOLD    = 2500000,
    parameter int CNT_W       = 26
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       AUX_INPUT,
    input  logic       MODE_VALID,
    input  logic       MODE_BIT,
    input  logic       FAULT_CLR,
    output logic       RELAY_A,
    output logic       RELAY_B,
    output logic       BUSY,
    output logic       FAULT,
    output logic [2:0] STATE_DBG
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DEAD    = 3'd1,
        S_DRIVE_A = 3'd2,
        S_DRIVE_B = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_TIME - 1);
    localparam logic [CNT_W-1:0] LOS_MAX   = CNT_W'(LOS_TIMEOUT);

    state_t           state;
    logic             target;
    logic [CNT_W-1:0] dead_cnt;
    logic [CNT_W-1:0] los_cnt;
    logic             aux_meta;
    logic             aux_sync;
    logic             aux_prev;

    logic aux_rise;
    logic los_hit;
    logic los_clr;
    logic dead_sel;
    logic cur_a;
    logic opposite;

    assign aux_rise = aux_sync & ~aux_prev;
    assign los_hit  = (los_cnt == LOS_MAX);
    assign los_clr  = (state == S_FAULT) && FAULT_CLR;
    // a request arriving on the terminal dead cycle still picks the drive
    assign dead_sel = MODE_VALID ? MODE_BIT : target;
    assign cur_a    = (state == S_DRIVE_A);
    assign opposite = MODE_VALID && (MODE_BIT != cur_a);

    assign STATE_DBG = state;

`ifdef RELAY_MIN_HOLD_EN
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MIN_HOLD);

    logic [CNT_W-1:0] hold_cnt;
    logic             pending;
    logic             hold_sat;

    assign hold_sat = (hold_cnt == HOLD_MAX);
`else
    logic unused_hold;
    assign unused_hold = ^MIN_HOLD;
`endif

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            aux_meta <= 1'b0;
            aux_sync <= 1'b0;
            aux_prev <= 1'b0;
        end else begin
            aux_meta <= AUX_INPUT;
            aux_sync <= aux_meta;
            aux_prev <= aux_sync;
        end
    end

    // activity watchdog: saturates instead of wrapping
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            los_cnt <= '0;
        end else if (aux_rise || los_clr) begin
            los_cnt <= '0;
        end else if (!los_hit) begin
            los_cnt <= los_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= S_IDLE;
            target   <= 1'b0;
            dead_cnt <= '0;
            RELAY_A  <= 1'b0;
            RELAY_B  <= 1'b0;
            BUSY     <= 1'b0;
            FAULT    <= 1'b0;
`ifdef RELAY_MIN_HOLD_EN
            hold_cnt <= '0;
            pending  <= 1'b0;
`endif
        end else begin
            // outputs decode the current state; any stray encoding
            // therefore yields both relays off
            RELAY_A <= (state == S_DRIVE_A);
            RELAY_B <= (state == S_DRIVE_B);
            BUSY    <= (state == S_DEAD);
            FAULT   <= (state == S_FAULT);
            unique case (state)
                S_IDLE: begin
                    if (MODE_VALID) begin
                        target   <= MODE_BIT;
                        dead_cnt <= '0;
                        state    <= S_DEAD;
                    end
                end
                S_DEAD: begin
                    if (MODE_VALID) begin
                        target <= MODE_BIT;
                    end
                    if (dead_cnt == DEAD_LAST) begin
                        dead_cnt <= '0;
                        state    <= dead_sel ? S_DRIVE_A : S_DRIVE_B;
`ifdef RELAY_MIN_HOLD_EN
                        hold_cnt <= '0;
                        pending  <= 1'b0;
`endif
                    end else begin
                        dead_cnt <= dead_cnt + 1'b1;
                    end
                end
                S_DRIVE_A, S_DRIVE_B: begin
`ifdef RELAY_MIN_HOLD_EN
                    if (!hold_sat) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                    if (los_hit) begin
                        pending <= 1'b0;
                        state   <= S_FAULT;
                    end else if (hold_sat && (opposite || pending)) begin
                        pending  <= 1'b0;
                        target   <= ~cur_a;
                        dead_cnt <= '0;
                        state    <= S_DEAD;
                    end else if (opposite) begin
                        pending <= 1'b1;
                    end else if (MODE_VALID) begin
                        pending <= 1'b0;
                    end
`else
                    if (los_hit) begin
                        state <= S_FAULT;
                    end else if (opposite) begin
                        target   <= MODE_BIT;
                        dead_cnt <= '0;
                        state    <= S_DEAD;
                    end
`endif
                end
                S_FAULT: begin
                    if (FAULT_CLR) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
